// File: rtl/upsample_pkg.sv
// Shared definitions for the 2x nearest-neighbour upsampler.
package upsample_pkg;

   // state | meaning
   // TOP_A | upper output row, waiting to accept a pixel and emit its first copy
   // TOP_B | upper output row, emitting the second copy of the held pixel
   // BOT   | lower output row, replaying the line buffer twice per pixel
   // DRAIN | last pixel of the frame loaded, waiting for it to fire
   typedef enum logic [1:0] {
      TOP_A = 2'd0,
      TOP_B = 2'd1,
      BOT   = 2'd2,
      DRAIN = 2'd3
   } us_state_t;

   // Column/row counters carry one spare bit so the row count can reach IF_SIZE.
   function automatic int cnt_width(input int if_size);
      return $clog2(if_size) + 1;
   endfunction

   // Line buffer address width; never zero so IF_SIZE=1 still has a legal port.
   function automatic int addr_width(input int if_size);
      return (if_size > 1) ? $clog2(if_size) : 1;
   endfunction

endpackage

// File: rtl/upsample2_line_buf.sv
// One-row pixel store: written while the upper output row streams, replayed
// for the lower output row.
module line_buf
   import upsample_pkg::*;
#(
   parameter int  BW      = 16,
   parameter int  IF_SIZE = 4,
   localparam int AW      = addr_width(IF_SIZE)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [BW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [BW-1:0] rd_data
);

   logic [BW-1:0] mem [0:(1<<AW)-1];

   // Storage has no reset: every entry is written before it is read in a frame.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsample2.sv
// Nearest-neighbour 2x upsampler: each input pixel becomes a 2x2 output block.
module upsample2
   import upsample_pkg::*;
#(
   parameter int BW      = 16,
   parameter int IF_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 global_rst_n,
   input  logic                 rst,
   input  logic signed [BW-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_in_ready,
   output logic signed [BW-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_out_ready,
   output logic                 o_end
);

   localparam int CW = cnt_width(IF_SIZE);
   localparam int AW = addr_width(IF_SIZE);
   localparam logic [CW-1:0] LAST = CW'(IF_SIZE - 1);

   us_state_t              state_q, state_d;
   logic [CW-1:0]          col_q, col_d;
   logic [CW-1:0]          row_q, row_d;
   logic                   sub_q, sub_d;
   logic signed [BW-1:0]   data_d;
   logic                   valid_d;
   logic                   end_d;
   logic                   out_fire;
   logic                   free;
   logic                   in_fire;
   logic                   lb_we;
   logic [BW-1:0]          lb_rd;

   assign out_fire = o_valid & i_out_ready;
   assign free     = !o_valid | out_fire;

   line_buf #(
      .BW      (BW),
      .IF_SIZE (IF_SIZE)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (lb_we),
      .wr_addr (col_q[AW-1:0]),
      .wr_data (i_data),
      .rd_addr (col_q[AW-1:0]),
      .rd_data (lb_rd)
   );

   // Next-state and handshake decode; the output register only moves when free.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      sub_d      = sub_q;
      data_d     = o_data;
      valid_d    = o_valid;
      end_d      = 1'b0;
      o_in_ready = 1'b0;
      in_fire    = 1'b0;
      lb_we      = 1'b0;
      unique case (state_q)
         TOP_A: begin
            // A soft clear wins over an offered pixel, so never claim to take it.
            o_in_ready = free & !rst;
            in_fire    = i_valid & o_in_ready;
            if (in_fire) begin
               data_d  = i_data;
               valid_d = 1'b1;
               lb_we   = 1'b1;
               state_d = TOP_B;
            end else if (free) begin
               valid_d = 1'b0;
            end
         end
         TOP_B: begin
            // The held pixel stays valid; its second copy is this same beat.
            if (out_fire) begin
               if (col_q == LAST) begin
                  col_d   = '0;
                  sub_d   = 1'b0;
                  state_d = BOT;
               end else begin
                  col_d   = col_q + CW'(1);
                  state_d = TOP_A;
               end
            end
         end
         BOT: begin
            if (free) begin
               data_d  = lb_rd;
               valid_d = 1'b1;
               sub_d   = ~sub_q;
               if (sub_q) begin
                  if (col_q == LAST) begin
                     col_d   = '0;
                     row_d   = row_q + CW'(1);
                     state_d = (row_q == LAST) ? DRAIN : TOP_A;
                  end else begin
                     col_d = col_q + CW'(1);
                  end
               end
            end
         end
         DRAIN: begin
            if (out_fire) begin
               valid_d = 1'b0;
               end_d   = 1'b1;
               row_d   = '0;
               state_d = TOP_A;
            end
         end
         default: state_d = TOP_A;
      endcase
   end

   // State, counters and output register; soft clear mirrors the async reset.
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         state_q <= TOP_A;
         col_q   <= '0;
         row_q   <= '0;
         sub_q   <= 1'b0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_end   <= 1'b0;
      end else if (rst) begin
         state_q <= TOP_A;
         col_q   <= '0;
         row_q   <= '0;
         sub_q   <= 1'b0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_end   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         sub_q   <= sub_d;
         o_data  <= data_d;
         o_valid <= valid_d;
         o_end   <= end_d;
      end
   end

endmodule
